// File: rtl/digit_text_emitter_pkg.sv
// Shared constants for the digit text emitter: glyph codes, default sizes,
// the 2-bit state encoding and a BCD validity helper.
package digit_text_emitter_pkg;

  localparam int          NDIG_DEFAULT        = 6;
  localparam int          ADDR_W_DEFAULT      = 11;
  localparam logic [7:0]  GLYPH_ZERO_DEFAULT  = 8'h30;
  localparam logic [7:0]  GLYPH_BLANK_DEFAULT = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/digit_text_emitter_if.sv
// Text/tile memory write port: req/ack handshake with address and glyph code.
interface digit_text_emitter_if
  import digit_text_emitter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input  wr_ack);
  modport slave  (input  wr_req, input  wr_addr, input  wr_data, output wr_ack);

endinterface

// File: rtl/digit_text_emitter_digit_glyph.sv
// Combinational mapper from one BCD digit plus its hide bit to a glyph code;
// non-decimal nibbles render as blank.
module digit_glyph
  import digit_text_emitter_pkg::*;
#(
  parameter logic [7:0] GLYPH_ZERO  = GLYPH_ZERO_DEFAULT,
  parameter logic [7:0] GLYPH_BLANK = GLYPH_BLANK_DEFAULT
) (
  input  logic [3:0] digit,
  input  logic       hide,
  output logic [7:0] glyph
);

  // Blank for hidden or non-BCD digits, otherwise offset from the zero glyph.
  always_comb begin
    glyph = GLYPH_BLANK;
    if (hide) begin
      glyph = GLYPH_BLANK;
    end else if (is_bcd(digit)) begin
      glyph = GLYPH_ZERO + {4'd0, digit};
    end else begin
      glyph = GLYPH_BLANK;
    end
  end

endmodule

// File: rtl/digit_text_emitter.sv
// Snapshots a BCD digit vector on start and writes one glyph per position, MSD first.
// Optional DIGIT_TEXT_SKIP_UNCHANGED_EN skips positions whose glyph is already on screen.
module digit_text_emitter
  import digit_text_emitter_pkg::*;
#(
  parameter int         NDIG        = NDIG_DEFAULT,
  parameter int         ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [7:0] GLYPH_ZERO  = GLYPH_ZERO_DEFAULT,
  parameter logic [7:0] GLYPH_BLANK = GLYPH_BLANK_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NDIG-1:0]    data,
  input  logic [NDIG-1:0]      mask,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  digit_text_emitter_if.master wr
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t              state_r, next_state_s;
  logic [IDX_W-1:0]    idx_r, next_idx_s;
  logic [4*NDIG-1:0]   data_snap_r, next_data_s;
  logic [NDIG-1:0]     mask_snap_r, next_mask_s;
  logic [ADDR_W-1:0]   base_snap_r, next_base_s;
  logic                advance_s;
  logic [3:0]          digits_s [NDIG];
  logic [3:0]          digit_sel_s;
  logic                hide_sel_s;
  logic [7:0]          glyph_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                wr_req_s;
  logic                wr_req_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [7:0]          wr_data_r;
  logic                busy_r;
  logic                done_r;

  // State, position index and input snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      data_snap_r <= {(4*NDIG){1'b0}};
      mask_snap_r <= {NDIG{1'b0}};
      base_snap_r <= {ADDR_W{1'b0}};
    end else begin
      state_r     <= next_state_s;
      idx_r       <= next_idx_s;
      data_snap_r <= next_data_s;
      mask_snap_r <= next_mask_s;
      base_snap_r <= next_base_s;
    end
  end

  // Next state; a skipped position (no request raised) advances without an ack.
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    next_data_s  = data_snap_r;
    next_mask_s  = mask_snap_r;
    next_base_s  = base_snap_r;
    advance_s    = wr_req_r ? wr.wr_ack : 1'b1;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_data_s  = data;
          next_mask_s  = mask;
          next_base_s  = base_addr;
          next_idx_s   = IDX_W'(NDIG - 1);
          next_state_s = EMIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      EMIT: begin
        if (advance_s) begin
          if (idx_r == {IDX_W{1'b0}}) begin
            next_state_s = DONE;
          end else begin
            next_idx_s = idx_r - IDX_W'(1);
          end
        end else begin
          next_state_s = EMIT;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Glyph and address for the position that will be presented next cycle.
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      digits_s[i] = next_data_s[4*i +: 4];
    end
    digit_sel_s = digits_s[next_idx_s];
    hide_sel_s  = next_mask_s[next_idx_s];
    addr_s      = next_base_s + ADDR_W'(NDIG - 1) - ADDR_W'(next_idx_s);
  end

  digit_glyph #(
    .GLYPH_ZERO  (GLYPH_ZERO),
    .GLYPH_BLANK (GLYPH_BLANK)
  ) u_digit_glyph (
    .digit (digit_sel_s),
    .hide  (hide_sel_s),
    .glyph (glyph_s)
  );

`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
  logic [7:0]        cache_r [NDIG];
  logic              cache_valid_r;
  logic [ADDR_W-1:0] cache_base_r;
  logic              skip_s;

  // A position is skipped when the screen already holds the same glyph at the same base.
  always_comb begin
    skip_s   = cache_valid_r && (next_base_s == cache_base_r) &&
               (glyph_s == cache_r[next_idx_s]);
    wr_req_s = (next_state_s == EMIT) && !skip_s;
  end

  // Cache of last written glyphs; validated at the end of a run, dropped on a base change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_r <= 1'b0;
      cache_base_r  <= {ADDR_W{1'b0}};
      for (int i = 0; i < NDIG; i++) begin
        cache_r[i] <= 8'h00;
      end
    end else begin
      if (wr_req_r && wr.wr_ack) begin
        cache_r[idx_r] <= wr_data_r;
      end else begin
        cache_r[idx_r] <= cache_r[idx_r];
      end
      if (state_r == DONE) begin
        cache_valid_r <= 1'b1;
        cache_base_r  <= base_snap_r;
      end else if ((state_r == IDLE) && start && (base_addr != cache_base_r)) begin
        cache_valid_r <= 1'b0;
      end else begin
        cache_valid_r <= cache_valid_r;
      end
    end
  end
`else
  // Every position in a run is written.
  always_comb begin
    wr_req_s = (next_state_s == EMIT);
  end
`endif

  // Registered outputs; address and glyph only change when a position is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_req_r  <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      wr_req_r <= wr_req_s;
      busy_r   <= (next_state_s != IDLE);
      done_r   <= (next_state_s == DONE);
      if (next_state_s == EMIT) begin
        wr_addr_r <= addr_s;
        wr_data_r <= glyph_s;
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
    end
  end

  assign wr.wr_req  = wr_req_r;
  assign wr.wr_addr = wr_addr_r;
  assign wr.wr_data = wr_data_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_digit_text_emitter.sv
// Directed bench for digit_text_emitter: per-cycle compare against a write-list model
// plus literal write logs and done timings; feature run under DIGIT_TEXT_SKIP_UNCHANGED_EN.
module tb_digit_text_emitter;

  localparam int NDIG   = 6;
  localparam int ADDR_W = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] data = 24'h0;
  logic [5:0]  mask = 6'h0;
  logic [10:0] base_addr = 11'h0;
  logic        busy;
  logic        done;

  digit_text_emitter_if #(.ADDR_W(ADDR_W)) wif ();

  digit_text_emitter #(.NDIG(NDIG), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .mask      (mask),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .wr        (wif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_off = -1;
  logic [18:0] wlog[$];
  int          wcyc[$];

  // model: list of expected writes for the current run
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  int          m_pos = 0;
  logic [10:0] m_base;
  logic [10:0] m_addr [NDIG];
  logic [7:0]  m_data [NDIG];
`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
  logic [7:0]  m_cache [NDIG];
  bit          m_cvalid = 1'b0;
  logic [10:0] m_cbase;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_glyph(input logic [3:0] d, input logic h);
    if (h || d > 4'd9) return 8'h20;
    return 8'h30 + {4'h0, d};
  endfunction

  initial begin : compare
    bit exp_req;
    bit skip;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        m_pos    = 0;
`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
        m_cvalid = 1'b0;
`endif
        chk("rst_req",  {31'd0, wif.wr_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {21'd0, wif.wr_addr}, 32'd0);
        chk("rst_data", {24'd0, wif.wr_data}, 32'd0);
      end else begin
        skip = 1'b0;
`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
        if (m_active && !m_done)
          skip = m_cvalid && (m_base == m_cbase) && (m_data[m_pos] == m_cache[m_pos]);
`endif
        exp_req = m_active && !m_done && !skip;
        chk("wr_req", {31'd0, wif.wr_req}, {31'd0, exp_req});
        chk("busy",   {31'd0, busy}, {31'd0, m_active});
        chk("done",   {31'd0, done}, {31'd0, m_done});
        if (exp_req) begin
          chk("wr_addr", {21'd0, wif.wr_addr}, {21'd0, m_addr[m_pos]});
          chk("wr_data", {24'd0, wif.wr_data}, {24'd0, m_data[m_pos]});
        end
        if (wif.wr_req && wif.wr_ack) begin
          wlog.push_back({wif.wr_addr, wif.wr_data});
          wcyc.push_back(cyc - t0);
        end
        if (done) done_off = cyc - t0;
        if (m_done) begin
          m_done   = 1'b0;
          m_active = 1'b0;
        end else if (m_active) begin
          if (skip || wif.wr_ack) begin
`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
            if (!skip) m_cache[m_pos] = m_data[m_pos];
`endif
            m_pos++;
            if (m_pos == NDIG) begin
              m_done = 1'b1;
`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
              m_cvalid = 1'b1;
              m_cbase  = m_base;
`endif
            end
          end
        end else if (start) begin
          m_base = base_addr;
          for (int p = 0; p < NDIG; p++) begin
            m_addr[p] = base_addr + 11'(p);
            m_data[p] = ref_glyph(data[4*(NDIG-1-p) +: 4], mask[NDIG-1-p]);
          end
          m_pos    = 0;
          m_active = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    wif.wr_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic launch(input logic [23:0] d, input logic [5:0] m, input logic [10:0] b);
    wlog.delete();
    wcyc.delete();
    done_off = -1;
    data = d;
    mask = m;
    base_addr = b;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60 && done_off < 0; i++) tick();
    chk({name, "_done_seen"}, {31'd0, (done_off >= 0)}, 32'd1);
  endtask

  task automatic check_log(input string name, input logic [18:0] e [NDIG]);
    chk({name, "_count"}, wlog.size(), NDIG);
    for (int i = 0; i < NDIG; i++)
      if (i < wlog.size()) chk($sformatf("%s_write%0d", name, i), {13'd0, wlog[i]}, {13'd0, e[i]});
  endtask

  logic [18:0] exp_basic [NDIG];
  logic [18:0] exp_wrap  [NDIG];

  initial begin
    exp_basic = '{ {11'h040, 8'h20}, {11'h041, 8'h20}, {11'h042, 8'h20},
                   {11'h043, 8'h31}, {11'h044, 8'h32}, {11'h045, 8'h33} };
    exp_wrap  = '{ {11'h7FE, 8'h30}, {11'h7FF, 8'h30}, {11'h000, 8'h20},
                   {11'h001, 8'h30}, {11'h002, 8'h30}, {11'h003, 8'h30} };
    wif.wr_ack = 1'b0;

    // basic emission, ack tied high
    do_reset();
    wif.wr_ack = 1'b1;
    launch(24'h000123, 6'b111000, 11'h040);
    wait_done("basic");
    check_log("basic", exp_basic);
    chk("basic_done_cyc", done_off, 32'd7);
    chk("basic_first_cyc", wcyc.size() > 0 ? wcyc[0] : -1, 32'd1);
    chk("basic_last_cyc", wcyc.size() > 5 ? wcyc[5] : -1, 32'd6);

    // ack held low for cycles 2..4 during the second write
    do_reset();
    wif.wr_ack = 1'b1;
    launch(24'h000123, 6'b111000, 11'h040);
    tick();
    wif.wr_ack = 1'b0;
    tick();
    tick();
    chk("bp_hold_req",  {31'd0, wif.wr_req}, 32'd1);
    chk("bp_hold_addr", {21'd0, wif.wr_addr}, 32'h041);
    chk("bp_hold_data", {24'd0, wif.wr_data}, 32'h20);
    tick();
    wif.wr_ack = 1'b1;
    wait_done("bp");
    check_log("bp", exp_basic);
    chk("bp_done_cyc", done_off, 32'd10);

    // start and data change while busy are ignored
    do_reset();
    wif.wr_ack = 1'b1;
    launch(24'h000123, 6'b111000, 11'h040);
    tick();
    tick();
    data = 24'h999999;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start");
    check_log("busy_start", exp_basic);
    chk("busy_start_done_cyc", done_off, 32'd7);
    repeat (6) tick();
    chk("busy_start_no_rerun", wlog.size(), 32'd6);

    // invalid digit and address wrap
    do_reset();
    wif.wr_ack = 1'b1;
    launch(24'h00A000, 6'b000000, 11'h7FE);
    wait_done("wrap");
    check_log("wrap", exp_wrap);

    // asynchronous reset during the fourth write
    do_reset();
    wif.wr_ack = 1'b1;
    launch(24'h000123, 6'b111000, 11'h040);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req",  {31'd0, wif.wr_req}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    launch(24'h000123, 6'b111000, 11'h040);
    wait_done("after_rst");
    check_log("after_rst", exp_basic);
    chk("after_rst_done_cyc", done_off, 32'd7);

`ifdef DIGIT_TEXT_SKIP_UNCHANGED_EN
    // second run at the same base only rewrites the changed units digit
    do_reset();
    wif.wr_ack = 1'b1;
    launch(24'h000123, 6'b111000, 11'h040);
    wait_done("skip_first");
    check_log("skip_first", exp_basic);
    tick();
    launch(24'h000124, 6'b111000, 11'h040);
    wait_done("skip_second");
    chk("skip_count", wlog.size(), 32'd1);
    chk("skip_write", wlog.size() > 0 ? {13'd0, wlog[0]} : 32'hFFFFFFFF, {13'd0, 11'h045, 8'h34});
    chk("skip_done_cyc", done_off, 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
